// File: rtl/arb_pkg.sv
// Shared types, sizes and the round-robin pick function for the
// four-way decoded arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Scan ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap) and return the first
  // requester found. The result is only meaningful when req is non-zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    winner = ptr;
    found  = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = ptr + IDX_W'(off);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/dec2to4_onehot.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module dec2to4_onehot
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] y
);

  // Raise exactly the selected line when enabled.
  always_comb begin
    y = '0;
    if (en) begin
      y[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Four-way round-robin arbiter. The winner is held as a registered 2-bit
// index and decoded to a one-hot grant. An owner keeps the grant until it
// drops its request or the hold-timeout forces a release; every release is
// followed by one idle arbitration cycle.
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  localparam int              CNT_W       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int              HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_LAST_I);
  localparam logic            TIMEOUT_EN  = (MAX_HOLD > 0);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] winner;

  // State, pointer, owner index, hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Arbitrate in IDLE; in BUSY track tenure and decide voluntary or forced release.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    winner    = rr_pick(req, ptr_q);
    case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = winner;
          ptr_d   = winner + IDX_W'(1);
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req[idx_q]) begin
          state_d = IDLE;
        end else if (TIMEOUT_EN && (cnt_q == HOLD_LAST)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant_valid = (state_q == BUSY);
  assign grant_idx   = idx_q;
  assign timeout     = timeout_q;

  dec2to4_onehot u_dec (
    .idx (idx_q),
    .en  (grant_valid),
    .y   (grant)
  );

endmodule

// File: doc/rr_decode_arbiter.md
# rr_decode_arbiter

Four-way round-robin arbiter that shares one decoded resource-select line between four requesters. It encodes the winning requester as a 2-bit index and drives it through a 2-to-4 one-hot decoder to produce the grant vector. A grant is held until the owner drops its request or a hold-timeout expires. Sits between requester logic and any 2-bit-addressed shared resource (bus, memory bank, output port).

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold the grant; 0 disables the timeout.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 4: request per requester, level-sensitive; bit i belongs to requester i.
- `grant` output 4: one-hot grant, decoded from `grant_idx`; all-zero when `grant_valid`=0.
- `grant_idx` output 2: index of current owner; holds its last value when idle.
- `grant_valid` output 1: a grant is active.
- `timeout` output 1: one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation
- FSM states: IDLE, BUSY.
- Reset, asynchronous on `rst_n`=0:
  - State = IDLE.
  - `grant`=0000, `grant_idx`=00, `grant_valid`=0, `timeout`=0.
  - Round-robin pointer `ptr`=00, hold counter=0.
- IDLE: if `req`≠0, pick the first set bit scanning `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
  - Register the winner into `grant_idx`, set `grant_valid`=1 and go to BUSY.
  - Set `ptr`=winner+1 (mod 4, 2-bit wrap) and clear the hold counter.
  - If `req`=0, stay in IDLE.
- BUSY, owner `o`=`grant_idx`:
  - `req[o]`=0 → release: `grant_valid`=0, go to IDLE.
  - `req[o]`=1 and `MAX_HOLD`>0 and counter = `MAX_HOLD`-1 → force release: `grant_valid`=0, `timeout`=1 for one cycle, go to IDLE.
  - Otherwise stay in BUSY and increment the counter.
  - Requests from non-owners are ignored while BUSY; there is no preemption.
- Every release, voluntary or forced, is followed by exactly one IDLE cycle with `grant`=0000. This is the arbitration cycle.
- A timed-out requester that still requests loses to any other requester on the next arbitration, because `ptr` has already advanced past it. It wins again only if it is the sole requester.
- Hold counter:
  - Width is `$clog2(MAX_HOLD+1)`, minimum 1.
  - Saturates and never wraps.
  - Unused when `MAX_HOLD`=0.
- `grant` is purely combinational from the registered `grant_idx` and `grant_valid` through the decoder: `grant[i]` = `grant_valid` & (`grant_idx`==i).

## Timing
- Arbitration latency: `req` sampled at edge t in IDLE → `grant` valid after edge t, i.e. one clock.
- Release latency: `req[o]` low sampled at edge t → `grant`=0 after edge t. A new grant appears after edge t+1.
- Maximum owner tenure: `MAX_HOLD` cycles with `grant_valid`=1. `timeout` is high during the first IDLE cycle after the forced release.
- Back-to-back grants to different requesters are always separated by one idle cycle. Peak throughput is one new grant every (tenure+1) cycles.
- Simultaneous owner release and new requests are handled by the single IDLE arbitration cycle. The releasing owner is eligible only at lowest priority.
- `rst_n` asserted mid-BUSY: all outputs drop within the reset assertion, with no clock required. After deassertion, arbitration restarts from `ptr`=00.
- `req` changes within a cycle are only sampled at the rising edge. There are no combinational paths from `req` to any output.

## Structure
- Package `arb_pkg` holds:
  - `NUM_REQ`=4 and `IDX_W`=2.
  - The state enum `arb_state_t` {IDLE, BUSY}.
  - The function `rr_pick(req, ptr)` returning the 2-bit winner.
- Sub-module `dec2to4_onehot`: combinational, inputs `idx[1:0]` and `en`, output `y[3:0]`. It is instantiated once to form `grant`.
- Top-level contents: FSM, pointer, hold counter, output registers.

## Test plan
1. Reset then single requester: `req`=0100 held for 5 cycles → `grant`=0100 and `grant_idx`=10 one cycle after sampling. Drop `req` → `grant`=0000 the next cycle, `ptr`=11.
2. Round-robin fairness: `req`=1111 held, each owner dropping after 2 cycles and re-raising → grant order 0001, 0010, 0100, 1000, 0001, each tenure separated by one idle cycle.
3. Timeout with `MAX_HOLD`=4: `req`=0001 held continuously → `grant_valid` high exactly 4 cycles, then `timeout` pulses for 1 cycle. With `req`=0011, the next grant is 0010.
4. Sole timed-out requester: `req`=0001 only, `MAX_HOLD`=4 → repeating pattern of 4 grant cycles, 1 idle cycle with `timeout`=1, then re-grant 0001.
5. Async reset mid-grant: `grant`=1000, assert `rst_n`=0 between edges → all outputs 0 immediately. After release with `req`=1001, the first grant is 0001 because `ptr`=00.
6. `MAX_HOLD`=0: `req`=0010 held 100 cycles → `grant` stays 0010 throughout and `timeout` never asserts.
